// File: rtl/or1k_boot_copier.sv
// Wishbone initiator that copies WORD_COUNT words from SRC_BASE to DST_BASE and holds the CPU in reset until done.
// Optional per-transfer ack timeout is enabled by defining BOOT_COPY_TIMEOUT_EN.
module or1k_boot_copier #(
    parameter logic [31:0] SRC_BASE   = 32'hB000_0000,
    parameter logic [31:0] DST_BASE   = 32'h0000_0000,
    parameter int unsigned WORD_COUNT = 256,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        start_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        timeout_o,
    output logic        cpu_rst_o
);
    localparam int IW = (WORD_COUNT < 1) ? 1 : $clog2(WORD_COUNT + 1);
    localparam logic [IW-1:0] LAST = IW'(WORD_COUNT);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RGAP, S_WR, S_WGAP, S_DONE, S_ERR
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_inc;
    logic          tmo_hit;
    logic          abort;

    assign idx_inc   = idx + 1'b1;
    assign wbm_sel_o = 4'hF;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [IW-1:0] i);
        return base + (32'(i) << 2);
    endfunction

`ifdef BOOT_COPY_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = wbm_stb_o && !wbm_ack_i && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // err outranks a simultaneous ack; ack/err while stb is low never reach this term
    assign abort = wbm_stb_o && (wbm_err_i || tmo_hit);

    // NOTE: every register here is state, so all assignments are non-blocking
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            cpu_rst_o <= 1'b1;
`ifdef BOOT_COPY_TIMEOUT_EN
            tmo_cnt   <= '0;
            timeout_o <= 1'b0;
`endif
        end else if (abort) begin
            state     <= S_ERR;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            busy_o    <= 1'b0;
            err_o     <= 1'b1;
`ifdef BOOT_COPY_TIMEOUT_EN
            timeout_o <= !wbm_err_i;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        idx       <= '0;
                        done_o    <= 1'b0;
                        err_o     <= 1'b0;
                        cpu_rst_o <= 1'b1;
`ifdef BOOT_COPY_TIMEOUT_EN
                        timeout_o <= 1'b0;
                        tmo_cnt   <= '0;
`endif
                        if (WORD_COUNT == 0) begin
                            state     <= S_DONE;
                            done_o    <= 1'b1;
                            cpu_rst_o <= 1'b0;
                        end else begin
                            state     <= S_RD;
                            busy_o    <= 1'b1;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b0;
                            wbm_adr_o <= SRC_BASE;
                        end
                    end
                end
                S_RD: begin
                    if (wbm_ack_i) begin
                        // the write-data register doubles as the holding register for the read word
                        wbm_dat_o <= wbm_dat_i;
                        wbm_stb_o <= 1'b0;
                        state     <= S_RGAP;
                    end
`ifdef BOOT_COPY_TIMEOUT_EN
                    else tmo_cnt <= tmo_cnt + 1'b1;
`endif
                end
                S_RGAP: begin
                    state     <= S_WR;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_adr_o <= word_addr(DST_BASE, idx);
`ifdef BOOT_COPY_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                S_WR: begin
                    if (wbm_ack_i) begin
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        idx       <= idx_inc;
                        if (idx_inc == LAST) begin
                            state     <= S_DONE;
                            wbm_cyc_o <= 1'b0;
                            busy_o    <= 1'b0;
                            done_o    <= 1'b1;
                            cpu_rst_o <= 1'b0;
                        end else begin
                            state <= S_WGAP;
                        end
                    end
`ifdef BOOT_COPY_TIMEOUT_EN
                    else tmo_cnt <= tmo_cnt + 1'b1;
`endif
                end
                S_WGAP: begin
                    state     <= S_RD;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b0;
                    wbm_adr_o <= word_addr(SRC_BASE, idx);
`ifdef BOOT_COPY_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_or1k_boot_copier.sv
// Bench for or1k_boot_copier: randomized slave timing/errors against a transaction-level model,
// plus directed runs for zero-length and address-wrap configurations.
module tb_or1k_boot_copier;
    localparam logic [31:0] SRC = 32'hB000_0000;
    localparam logic [31:0] DST = 32'h0000_0000;
    localparam int WC  = 4;
    localparam int TMO = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic start = 1'b0;
    logic [31:0] adr, dat_o, dat_i = '0;
    logic [3:0]  sel;
    logic we, cyc, stb, ack = 1'b0, err = 1'b0;
    logic busy, done, errf, tmo, cpu_rst;

    or1k_boot_copier #(.SRC_BASE(SRC), .DST_BASE(DST), .WORD_COUNT(WC), .TIMEOUT(TMO)) dut (
        .wb_clk(clk), .wb_rst_n(rst_n), .start_i(start),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_sel_o(sel),
        .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_ack_i(ack), .wbm_err_i(err),
        .busy_o(busy), .done_o(done), .err_o(errf), .timeout_o(tmo), .cpu_rst_o(cpu_rst)
    );

    // address-wrap instance
    logic start_w = 1'b0;
    logic [31:0] w_adr, w_dat_o, w_dat_i = '0;
    logic [3:0]  w_sel;
    logic w_we, w_cyc, w_stb, w_ack = 1'b0;
    logic w_busy, w_done, w_err, w_tmo, w_cpu_rst;

    or1k_boot_copier #(.SRC_BASE(32'h2000_0000), .DST_BASE(32'hFFFF_FFFC), .WORD_COUNT(2), .TIMEOUT(TMO)) dut_w (
        .wb_clk(clk), .wb_rst_n(rst_n), .start_i(start_w),
        .wbm_adr_o(w_adr), .wbm_dat_o(w_dat_o), .wbm_dat_i(w_dat_i), .wbm_sel_o(w_sel),
        .wbm_we_o(w_we), .wbm_cyc_o(w_cyc), .wbm_stb_o(w_stb), .wbm_ack_i(w_ack), .wbm_err_i(1'b0),
        .busy_o(w_busy), .done_o(w_done), .err_o(w_err), .timeout_o(w_tmo), .cpu_rst_o(w_cpu_rst)
    );

    // zero-length instance
    logic start_z = 1'b0;
    logic [31:0] z_adr, z_dat_o;
    logic [3:0]  z_sel;
    logic z_we, z_cyc, z_stb, z_busy, z_done, z_err, z_tmo, z_cpu_rst;

    or1k_boot_copier #(.SRC_BASE(SRC), .DST_BASE(DST), .WORD_COUNT(0), .TIMEOUT(TMO)) dut_z (
        .wb_clk(clk), .wb_rst_n(rst_n), .start_i(start_z),
        .wbm_adr_o(z_adr), .wbm_dat_o(z_dat_o), .wbm_dat_i(32'h0), .wbm_sel_o(z_sel),
        .wbm_we_o(z_we), .wbm_cyc_o(z_cyc), .wbm_stb_o(z_stb), .wbm_ack_i(1'b0), .wbm_err_i(1'b0),
        .busy_o(z_busy), .done_o(z_done), .err_o(z_err), .timeout_o(z_tmo), .cpu_rst_o(z_cpu_rst)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // slave knobs and memories
    int  fixed_wait = -1;
    bit  stall      = 1'b0;
    bit  spurious   = 1'b0;
    int  err_at     = -1;
    logic [31:0] src_mem [WC];
    logic [31:0] dst_mem [WC];
    int  writes_seen = 0;

    // transaction-level model: the list of bus transfers still owed, plus expected status flags
    typedef struct {
        logic        we;
        logic [31:0] adr;
        int          idx;
    } xfer_t;
    xfer_t q[$];
    bit m_active, m_gap, m_done, m_err, m_tmo, m_cpu_rst;
    int stb_cnt, wait_left, xfer_no;
    bit a_d, e_d;
    int mi;

    function automatic void model_reset();
        q.delete();
        m_active = 0; m_gap = 0; m_done = 0; m_err = 0; m_tmo = 0; m_cpu_rst = 1;
        stb_cnt = 0; wait_left = -1; xfer_no = 0;
    endfunction

    initial model_reset();

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            check("rst_adr", adr, 32'h0);
            check("rst_dat", dat_o, 32'h0);
            chk_b("rst_we", we, 1'b0);
            chk_b("rst_cyc", cyc, 1'b0);
            chk_b("rst_stb", stb, 1'b0);
            chk_b("rst_busy", busy, 1'b0);
            chk_b("rst_done", done, 1'b0);
            chk_b("rst_err", errf, 1'b0);
            chk_b("rst_cpu", cpu_rst, 1'b1);
            ack = 1'b0;
            err = 1'b0;
        end else begin
            chk_b("busy", busy, m_active);
            chk_b("done", done, m_done);
            chk_b("err", errf, m_err);
            chk_b("tmo", tmo, m_tmo);
            chk_b("cpu_rst", cpu_rst, m_cpu_rst);
            chk_b("cyc", cyc, m_active);
            chk_b("stb", stb, m_active && !m_gap);
            check("sel", {28'b0, sel}, 32'hF);
            if (m_active && !m_gap && q.size() > 0) begin
                check("adr", adr, q[0].adr);
                chk_b("we", we, q[0].we);
                if (q[0].we) check("wdat", dat_o, src_mem[q[0].idx]);
            end

            // slave response for the coming edge
            a_d = 0;
            e_d = 0;
            if (stb && cyc) begin
                if (wait_left < 0) wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
                if (!stall) begin
                    if (wait_left == 0) begin
                        a_d = 1;
                        wait_left = -1;
                        if (xfer_no == err_at) begin
                            e_d = 1;
                            a_d = 1'($urandom_range(0, 1));
                        end
                        xfer_no++;
                    end else begin
                        wait_left--;
                    end
                end
                mi = int'((adr - SRC) >> 2);
                dat_i = (a_d && !we && mi >= 0 && mi < WC) ? src_mem[mi] : $urandom;
                mi = int'((adr - DST) >> 2);
                if (a_d && !e_d && we && mi >= 0 && mi < WC) begin
                    dst_mem[mi] = dat_o;
                    writes_seen++;
                end
            end else begin
                if (spurious) begin
                    a_d = ($urandom_range(0, 3) == 0);
                    e_d = ($urandom_range(0, 7) == 0);
                end
                dat_i = $urandom;
            end
            ack = a_d;
            err = e_d;

            // model advance to next cycle
            if (m_active) begin
                if (m_gap) begin
                    m_gap = 0;
                end else if (e_d) begin
                    m_active = 0;
                    m_err = 1;
                    q.delete();
                end else if (a_d) begin
                    void'(q.pop_front());
                    stb_cnt = 0;
                    if (q.size() == 0) begin
                        m_active = 0;
                        m_done = 1;
                        m_cpu_rst = 0;
                    end else begin
                        m_gap = 1;
                    end
                end else begin
                    stb_cnt++;
`ifdef BOOT_COPY_TIMEOUT_EN
                    if (stb_cnt == TMO) begin
                        m_active = 0;
                        m_err = 1;
                        m_tmo = 1;
                        q.delete();
                    end
`endif
                end
            end else if (start) begin
                m_done = 0; m_err = 0; m_tmo = 0; m_cpu_rst = 1;
                xfer_no = 0; wait_left = -1; stb_cnt = 0; writes_seen = 0;
                for (int i = 0; i < WC; i++) begin
                    q.push_back('{we: 1'b0, adr: SRC + 32'(4 * i), idx: i});
                    q.push_back('{we: 1'b1, adr: DST + 32'(4 * i), idx: i});
                end
                m_active = 1;
                m_gap = 0;
            end
        end
    end

    // wrap-instance slave: immediate ack, data derived from address
    logic [31:0] w_wadr[$];
    logic [31:0] w_wdat[$];
    always @(negedge clk) begin
        w_ack   = w_stb && w_cyc;
        w_dat_i = w_adr ^ 32'h5A5A_0000;
        if (w_stb && w_cyc && w_we) begin
            w_wadr.push_back(w_adr);
            w_wdat.push_back(w_dat_o);
        end
    end

    bit z_bus_seen = 1'b0;
    always @(negedge clk) if (z_cyc || z_stb) z_bus_seen = 1'b1;

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (n < 400 && !(done || errf)) begin
            @(posedge clk); #1;
            n++;
        end
        chk_b({name, "_finished"}, done || errf, 1'b1);
    endtask

    task automatic clear_dst();
        for (int i = 0; i < WC; i++) dst_mem[i] = '0;
    endtask

    task automatic check_copy(input string name);
        for (int i = 0; i < WC; i++) check($sformatf("%s_word%0d", name, i), dst_mem[i], src_mem[i]);
    endtask

    task automatic randomize_src();
        for (int i = 0; i < WC; i++) src_mem[i] = $urandom;
    endtask

    initial begin
        int cycles;
        bit found;
        for (int i = 0; i < WC; i++) begin
            src_mem[i] = '0;
            dst_mem[i] = '0;
        end

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset_adr", adr, 32'h0);
        chk_b("reset_cpu_rst", cpu_rst, 1'b1);
        chk_b("reset_cyc", cyc, 1'b0);
        chk_b("z_reset_done", z_done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // boot image with a registered-ack slave: 24 cycles start-to-done
        src_mem[0] = 32'h1800_0000;
        src_mem[1] = 32'hA820_0000;
        src_mem[2] = 32'h1500_0000;
        src_mem[3] = 32'h4400_4800;
        fixed_wait = 1;
        clear_dst();
        @(posedge clk); #1 start = 1'b1;
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk); #1 start = 1'b0;
            cycles++;
            if (done) break;
        end
        check("t1_cycles", cycles, 24);
        check("t1_dst0", dst_mem[0], 32'h1800_0000);
        check("t1_dst1", dst_mem[1], 32'hA820_0000);
        check("t1_dst2", dst_mem[2], 32'h1500_0000);
        check("t1_dst3", dst_mem[3], 32'h4400_4800);
        chk_b("t1_cpu_rst", cpu_rst, 1'b0);
        check("t1_writes", writes_seen, 4);

        // error on the second read, then a clean restart
        fixed_wait = -1;
        randomize_src();
        clear_dst();
        err_at = 2;
        pulse_start();
        wait_end("t2");
        chk_b("t2_err", errf, 1'b1);
        chk_b("t2_cpu_rst", cpu_rst, 1'b1);
        chk_b("t2_cyc", cyc, 1'b0);
        check("t2_writes", writes_seen, 1);
        err_at = -1;
        clear_dst();
        pulse_start();
        wait_end("t2b");
        chk_b("t2b_done", done, 1'b1);
        check_copy("t2b");

        // slave that never acks
        stall = 1'b1;
        pulse_start();
`ifdef BOOT_COPY_TIMEOUT_EN
        wait_end("t3");
        chk_b("t3_err", errf, 1'b1);
        chk_b("t3_timeout", tmo, 1'b1);
`else
        repeat (1000) @(posedge clk);
        #1;
        chk_b("t3_stb_held", stb, 1'b1);
        chk_b("t3_busy", busy, 1'b1);
`endif
        stall = 1'b0;
        do_reset();

        // reset during the third write, then recopy from index 0
        randomize_src();
        clear_dst();
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (stb && we && adr == DST + 32'd8) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk_b("t4_third_write_seen", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_b("t4_cyc", cyc, 1'b0);
        chk_b("t4_stb", stb, 1'b0);
        chk_b("t4_cpu_rst", cpu_rst, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_dst();
        pulse_start();
        check("t4_first_adr", adr, SRC);
        wait_end("t4");
        chk_b("t4_done", done, 1'b1);
        check_copy("t4");

        // start while busy is ignored
        randomize_src();
        clear_dst();
        pulse_start();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk_b("t5_busy", busy, 1'b1);
        wait_end("t5");
        chk_b("t5_done", done, 1'b1);
        check_copy("t5");

        // randomized runs
        spurious = 1'b1;
        for (int r = 0; r < 25; r++) begin
            randomize_src();
            clear_dst();
            err_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2 * WC - 1)) : -1;
            repeat ($urandom_range(0, 4)) @(posedge clk);
            pulse_start();
            wait_end($sformatf("rnd%0d", r));
            if (err_at < 0) begin
                chk_b($sformatf("rnd%0d_done", r), done, 1'b1);
                check_copy($sformatf("rnd%0d", r));
            end else begin
                chk_b($sformatf("rnd%0d_err", r), errf, 1'b1);
                check($sformatf("rnd%0d_writes", r), writes_seen, err_at / 2);
            end
        end
        spurious = 1'b0;
        err_at = -1;

        // destination wraps past 2^32
        w_wadr.delete();
        w_wdat.delete();
        @(posedge clk); #1 start_w = 1'b1;
        @(posedge clk); #1 start_w = 1'b0;
        for (int n = 0; n < 100 && !w_done; n++) begin
            @(posedge clk); #1;
        end
        chk_b("wrap_done", w_done, 1'b1);
        check("wrap_nwrites", w_wadr.size(), 2);
        if (w_wadr.size() >= 2) begin
            check("wrap_adr0", w_wadr[0], 32'hFFFF_FFFC);
            check("wrap_adr1", w_wadr[1], 32'h0000_0000);
            check("wrap_dat0", w_wdat[0], 32'h7A5A_0000);
            check("wrap_dat1", w_wdat[1], 32'h7A5A_0004);
        end

        // zero-length copy
        @(posedge clk); #1 start_z = 1'b1;
        @(posedge clk); #1 start_z = 1'b0;
        chk_b("zero_done", z_done, 1'b1);
        chk_b("zero_busy", z_busy, 1'b0);
        chk_b("zero_cpu_rst", z_cpu_rst, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_b("zero_no_bus", z_bus_seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
